// File: rtl/display_pacer.sv
`default_nettype none
// ============================================================================
// Module   : display_pacer
// Purpose  : Queues CPU byte writes and shows each on DisplayValue for a fixed
//            hold interval, holding the last byte once the queue drains.
// Revision : 1.0 - initial release
// ============================================================================
module display_pacer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   WriteEnable,
    input  logic [7:0]             WriteData,
    input  logic                   Clear,
    output logic                   Ready,
    output logic [7:0]             DisplayValue,
    output logic                   Busy,
    output logic                   Overflow,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_hold_w = $clog2(HOLD_CYCLES) + 1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_addr_w:0]   c_full      = (c_addr_w + 1)'(DEPTH);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_show = 1'b1;

    logic [7:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic [c_hold_w-1:0] r_hold;
    logic [0:0]          r_state;
    logic [7:0]          r_display;
    logic                r_overflow;

    logic w_ready;
    logic w_wr_acc;
    logic w_pop;

    // Readiness comes only from the registered count, so a same-cycle pop
    // never frees a slot for the incoming write.
    assign w_ready  = (r_count != c_full);
    assign w_wr_acc = WriteEnable && w_ready && !Clear;
    assign w_pop    = (r_count != '0) &&
                      ((r_state == c_st_idle) || (r_hold == '0));

    always_ff @(posedge Clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hold     <= '0;
            r_state    <= c_st_idle;
            r_display  <= 8'h00;
            r_overflow <= 1'b0;
        end else if (Clear) begin
            r_rd_ptr   <= r_wr_ptr;
            r_count    <= '0;
            r_hold     <= '0;
            r_state    <= c_st_idle;
            r_overflow <= 1'b0;
        end else begin
            if (WriteEnable && !w_ready) begin
                r_overflow <= 1'b1;
            end

            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end

            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_addr_w'(1);
                r_display <= r_mem[r_rd_ptr];
                r_hold    <= c_hold_load;
                r_state   <= c_st_show;
            end else if (r_state == c_st_show) begin
                if (r_hold != '0) begin
                    r_hold <= r_hold - c_hold_w'(1);
                end else begin
                    r_state <= c_st_idle;
                end
            end

            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign Ready        = w_ready;
    assign DisplayValue = r_display;
    assign Busy         = (r_state == c_st_show);
    assign Overflow     = r_overflow;
    assign Count        = r_count;

endmodule
`default_nettype wire
